// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood fan controller.
package hood_pkg;

   localparam int unsigned MAX_MIN = 99;
   localparam int unsigned MAX_SEC = 59;
   localparam int unsigned MIN_W   = 7;
   localparam int unsigned SEC_W   = 6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      TURBO,
      PURGE
   } hood_state_t;

   typedef logic [3:0] bcd_nibble_t;

   typedef struct packed {
      bcd_nibble_t min_tens;
      bcd_nibble_t min_ones;
      bcd_nibble_t sec_tens;
      bcd_nibble_t sec_ones;
   } mmss_bcd_t;

   // Two-digit BCD of a binary value 0..99.
   function automatic logic [7:0] to_bcd2(input logic [MIN_W-1:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/hood_mmss_counter.sv
// Binary min:sec counter with BCD view; load, up/down, tick enable, wrap-or-stop.
module hood_mmss_counter
   import hood_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [MIN_W-1:0] load_min,
   input  logic [SEC_W-1:0] load_sec,
   input  logic             en,
   input  logic             up,
   input  logic             wrap,
   output mmss_bcd_t        bcd,
   output logic             is_zero,
   output logic             min_carry_c
);

   logic [MIN_W-1:0] min_q;
   logic [SEC_W-1:0] sec_q;
   logic             sec_max;
   logic             at_max;

   assign sec_max = (sec_q == SEC_W'(MAX_SEC));
   assign at_max  = sec_max && (min_q == MIN_W'(MAX_MIN));
   assign is_zero = (min_q == '0) && (sec_q == '0);

   // Pulses on the tick that rolls seconds over into the next minute.
   assign min_carry_c = en && !load && up && sec_max && (wrap || !at_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= '0;
         sec_q <= '0;
      end else if (load) begin
         min_q <= load_min;
         sec_q <= load_sec;
      end else if (en) begin
         if (up) begin
            if (at_max) begin
               if (wrap) begin
                  min_q <= '0;
                  sec_q <= '0;
               end
            end else if (sec_max) begin
               sec_q <= '0;
               min_q <= min_q + MIN_W'(1);
            end else begin
               sec_q <= sec_q + SEC_W'(1);
            end
         end else begin
            if (sec_q != '0) begin
               sec_q <= sec_q - SEC_W'(1);
            end else if (min_q != '0) begin
               min_q <= min_q - MIN_W'(1);
               sec_q <= SEC_W'(MAX_SEC);
            end else if (wrap) begin
               min_q <= MIN_W'(MAX_MIN);
               sec_q <= SEC_W'(MAX_SEC);
            end
         end
      end
   end

   assign bcd = {to_bcd2(min_q), to_bcd2(MIN_W'(sec_q))};

endmodule

// File: rtl/hood_fan_ctrl.sv
// N-level hood fan controller with limited turbo, delayed-off purge and run timer.
// Optional clean reminder enabled by defining HOOD_CLEAN_REMIND_EN.
module hood_fan_ctrl
   import hood_pkg::*;
#(
   parameter  int unsigned TICK_DIV      = 500,
   parameter  int unsigned NUM_SPEEDS    = 3,
   parameter  int unsigned TURBO_SECONDS = 60,
   parameter  int unsigned TURBO_USES    = 1,
   parameter  int unsigned OFF_DELAY_S   = 30,
   parameter  int unsigned CLEAN_MINUTES = 600,
   localparam int unsigned SW            = $clog2(NUM_SPEEDS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SW-1:0]         speed_req,
   input  logic                  clean_ack,
   output logic [SW-1:0]         fan_speed,
   output logic [NUM_SPEEDS-1:0] speed_led,
   output logic [15:0]           disp_bcd,
   output logic                  disp_is_countdown,
   output logic                  turbo_avail,
   output logic                  clean_remind
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned UW = (TURBO_USES > 0) ? $clog2(TURBO_USES + 1) : 1;

   localparam logic [MIN_W-1:0] TURBO_MIN = MIN_W'(TURBO_SECONDS / 60);
   localparam logic [SEC_W-1:0] TURBO_SEC = SEC_W'(TURBO_SECONDS % 60);
   localparam logic [MIN_W-1:0] OFF_MIN   = MIN_W'(OFF_DELAY_S / 60);
   localparam logic [SEC_W-1:0] OFF_SEC   = SEC_W'(OFF_DELAY_S % 60);

   hood_state_t      state;
   logic [SW-1:0]    req_prev;
   logic [UW-1:0]    uses_left;
   logic [TW-1:0]    tick_cnt;
   logic             tick;

   logic             req_valid, accepted;
   logic             is_run_lvl, is_off, turbo_ok;
   logic             go_run, go_turbo, go_off, take;
   logic             counting, expire;
   logic             cd_load, cd_en, cd_zero;
   logic [MIN_W-1:0] cd_load_min;
   logic [SEC_W-1:0] cd_load_sec;
   logic             cum_en, cum_zero, cum_carry_c, cd_carry_c;
   mmss_bcd_t        cum_bcd, cd_bcd;

   function automatic logic [NUM_SPEEDS-1:0] led_of(input logic [SW-1:0] s);
      logic [NUM_SPEEDS-1:0] led;
      for (int i = 0; i < NUM_SPEEDS; i++) led[i] = (s == SW'(i + 1));
      return led;
   endfunction

   // 1 Hz enable from the system clock.
   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + TW'(1);
   end

   // Edge-detected request; out-of-range levels are dropped but still tracked.
   assign req_valid  = ({1'b0, speed_req} <= (SW + 1)'(NUM_SPEEDS));
   assign accepted   = (speed_req != req_prev) && req_valid;
   assign is_run_lvl = (speed_req != '0) && (speed_req < SW'(NUM_SPEEDS));
   assign is_off     = (speed_req == '0);
   assign turbo_ok   = (speed_req == SW'(NUM_SPEEDS)) && (uses_left != '0);

   always_comb begin
      go_run   = 1'b0;
      go_turbo = 1'b0;
      go_off   = 1'b0;
      if (accepted) begin
         unique case (state)
            IDLE, PURGE: begin
               go_run   = is_run_lvl;
               go_turbo = turbo_ok;
            end
            RUN: begin
               go_run   = is_run_lvl;
               go_turbo = turbo_ok;
               go_off   = is_off;
            end
            TURBO: begin
               go_run = is_run_lvl;
               go_off = is_off;
            end
         endcase
      end
   end

   // A real transition pre-empts the countdown on a coincident tick.
   assign take        = go_run || go_turbo || go_off;
   assign counting    = (state == TURBO) || (state == PURGE);
   assign expire      = tick && counting && !take && cd_zero;
   assign cd_en       = tick && counting && !take;
   assign cd_load     = go_turbo || (go_off && (OFF_DELAY_S != 0));
   assign cd_load_min = go_turbo ? TURBO_MIN : OFF_MIN;
   assign cd_load_sec = go_turbo ? TURBO_SEC : OFF_SEC;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         fan_speed         <= '0;
         speed_led         <= '0;
         disp_is_countdown <= 1'b0;
         uses_left         <= UW'(TURBO_USES);
         req_prev          <= '0;
      end else begin
         req_prev <= speed_req;
         if (go_turbo) begin
            state             <= TURBO;
            fan_speed         <= SW'(NUM_SPEEDS);
            speed_led         <= led_of(SW'(NUM_SPEEDS));
            disp_is_countdown <= 1'b1;
            uses_left         <= uses_left - UW'(1);
         end else if (go_run) begin
            state             <= RUN;
            fan_speed         <= speed_req;
            speed_led         <= led_of(speed_req);
            disp_is_countdown <= 1'b0;
         end else if (go_off && (OFF_DELAY_S != 0)) begin
            state             <= PURGE;
            fan_speed         <= SW'(1);
            speed_led         <= led_of(SW'(1));
            disp_is_countdown <= 1'b1;
         end else if (go_off || (expire && (state == PURGE))) begin
            state             <= IDLE;
            fan_speed         <= '0;
            speed_led         <= '0;
            disp_is_countdown <= 1'b0;
         end else if (expire) begin
            state             <= RUN;
            fan_speed         <= SW'(NUM_SPEEDS - 1);
            speed_led         <= led_of(SW'(NUM_SPEEDS - 1));
            disp_is_countdown <= 1'b0;
         end
      end
   end

   assign turbo_avail = (uses_left != '0);

   // Run timer counts seconds of any nonzero drive, purge included.
   assign cum_en = tick && (fan_speed != '0);

   hood_mmss_counter u_cum (
      .clk         (clk),
      .rst         (rst),
      .load        (1'b0),
      .load_min    ('0),
      .load_sec    ('0),
      .en          (cum_en),
      .up          (1'b1),
      .wrap        (1'b1),
      .bcd         (cum_bcd),
      .is_zero     (cum_zero),
      .min_carry_c (cum_carry_c)
   );

   hood_mmss_counter u_cd (
      .clk         (clk),
      .rst         (rst),
      .load        (cd_load),
      .load_min    (cd_load_min),
      .load_sec    (cd_load_sec),
      .en          (cd_en),
      .up          (1'b0),
      .wrap        (1'b0),
      .bcd         (cd_bcd),
      .is_zero     (cd_zero),
      .min_carry_c (cd_carry_c)
   );

   assign disp_bcd = disp_is_countdown ? cd_bcd : cum_bcd;

   logic [1:0] misc_unused;
   assign misc_unused = {cum_zero, cd_carry_c};

`ifdef HOOD_CLEAN_REMIND_EN
   localparam int unsigned CW = (CLEAN_MINUTES > 0) ? $clog2(CLEAN_MINUTES + 1) : 1;

   logic [CW-1:0] clean_cnt;
   logic [CW-1:0] clean_inc;

   assign clean_inc = (clean_cnt == CW'(CLEAN_MINUTES)) ? clean_cnt : clean_cnt + CW'(1);

   // Saturating runtime-minute count; acknowledge beats a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst) begin
         clean_cnt    <= '0;
         clean_remind <= 1'b0;
      end else if (clean_ack) begin
         clean_cnt    <= '0;
         clean_remind <= 1'b0;
      end else if (cum_carry_c) begin
         clean_cnt <= clean_inc;
         if (clean_inc == CW'(CLEAN_MINUTES)) clean_remind <= 1'b1;
      end
   end
`else
   localparam int unsigned CLEAN_MINUTES_UNUSED = CLEAN_MINUTES;

   logic [1:0] clean_unused;
   assign clean_unused = {clean_ack, cum_carry_c};
   assign clean_remind = 1'b0;
`endif

endmodule

// File: tb/tb_hood_fan_ctrl.sv
// Self-checking bench for hood_fan_ctrl against a seconds-based reference model.
module tb_hood_fan_ctrl;

   localparam int TICK_DIV = 4;
   localparam int NS       = 3;
   localparam int TS       = 3;
   localparam int OD       = 2;
   localparam int TU       = 1;
   localparam int CM       = 1;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_TURBO = 2;
   localparam int M_PURGE = 3;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       clean_ack = 1'b0;
   logic [1:0] speed_req = 2'd0;
   logic [1:0] fan_speed;
   logic [2:0] speed_led;
   logic [15:0] disp_bcd;
   logic       disp_is_countdown, turbo_avail, clean_remind;

   int n_vec = 0;
   int n_err = 0;

   int m_mode, m_speed, m_cd, m_cum, m_uses, m_prev, m_phase, m_cmin;
   bit m_remind;

   always #5 clk = ~clk;

   hood_fan_ctrl #(
      .TICK_DIV      (TICK_DIV),
      .NUM_SPEEDS    (NS),
      .TURBO_SECONDS (TS),
      .TURBO_USES    (TU),
      .OFF_DELAY_S   (OD),
      .CLEAN_MINUTES (CM)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .speed_req         (speed_req),
      .clean_ack         (clean_ack),
      .fan_speed         (fan_speed),
      .speed_led         (speed_led),
      .disp_bcd          (disp_bcd),
      .disp_is_countdown (disp_is_countdown),
      .turbo_avail       (turbo_avail),
      .clean_remind      (clean_remind)
   );

   task automatic model_reset();
      m_mode = M_IDLE; m_speed = 0; m_cd = 0; m_cum = 0; m_uses = TU;
      m_prev = 0; m_phase = 0; m_cmin = 0; m_remind = 0;
   endtask

   // One clock of the reference behaviour, seconds-based.
   task automatic model_step();
      bit tick, acc, roll, moved;
      int r;
      if (rst) begin
         model_reset();
         return;
      end
      tick    = (m_phase == TICK_DIV - 1);
      m_phase = tick ? 0 : m_phase + 1;
      r       = int'(speed_req);
      acc     = (r != m_prev) && (r <= NS);
      m_prev  = r;
      roll    = 0;
      if (tick && m_speed != 0) begin
         m_cum = (m_cum + 1) % 6000;
         roll  = (m_cum % 60 == 0);
      end
`ifdef HOOD_CLEAN_REMIND_EN
      if (clean_ack) begin
         m_cmin = 0; m_remind = 0;
      end else if (roll) begin
         m_cmin = (m_cmin + 1 > CM) ? CM : m_cmin + 1;
         if (m_cmin == CM) m_remind = 1;
      end
`endif
      moved = 0;
      if (acc) begin
         if (r >= 1 && r < NS) begin
            m_mode = M_RUN; m_speed = r; moved = 1;
         end else if (r == NS && m_uses > 0 && m_mode != M_TURBO) begin
            m_mode = M_TURBO; m_speed = NS; m_cd = TS; m_uses--; moved = 1;
         end else if (r == 0 && (m_mode == M_RUN || m_mode == M_TURBO)) begin
            moved = 1;
            if (OD == 0) begin m_mode = M_IDLE; m_speed = 0; end
            else begin m_mode = M_PURGE; m_speed = 1; m_cd = OD; end
         end
      end
      if (!moved && tick && (m_mode == M_TURBO || m_mode == M_PURGE)) begin
         if (m_cd > 0) m_cd--;
         else if (m_mode == M_TURBO) begin m_mode = M_RUN; m_speed = NS - 1; end
         else begin m_mode = M_IDLE; m_speed = 0; end
      end
   endtask

   function automatic logic [23:0] exp_vec();
      int s, mm, ss;
      logic [2:0] led;
      logic cdn;
      cdn = (m_mode == M_TURBO || m_mode == M_PURGE);
      s   = cdn ? m_cd : m_cum;
      mm  = s / 60;
      ss  = s % 60;
      led = (m_speed == 0) ? 3'b000 : 3'(1 << (m_speed - 1));
      return {2'(m_speed), led, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              cdn, (m_uses != 0), m_remind};
   endfunction

   function automatic logic [23:0] dut_vec();
      return {fan_speed, speed_led, disp_bcd, disp_is_countdown, turbo_avail, clean_remind};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; speed_req = 2'd0;
      repeat (3) cyc();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
      end
      n_vec++;
      if ({fan_speed, speed_led, disp_bcd, disp_is_countdown, turbo_avail} !== {2'd0, 3'd0, 16'h0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL reset_const: got %h expected %h", dut_vec(), {2'd0, 3'd0, 16'h0, 3'b010});
      end
   endtask

   task automatic test_run_level();
      rst = 1'b0; speed_req = 2'd1;
      repeat (20) cyc();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL run_vec: got %h expected %h", dut_vec(), exp_vec());
      end
      n_vec++;
      if ({fan_speed, speed_led, disp_bcd, disp_is_countdown} !== {2'd1, 3'b001, 16'h0005, 1'b0}) begin
         n_err++; $display("FAIL run_const: got %h expected %h", {fan_speed, speed_led, disp_bcd, disp_is_countdown}, {2'd1, 3'b001, 16'h0005, 1'b0});
      end
   endtask

   task automatic test_turbo();
      logic [63:0] obs = '0;
      logic [15:0] last = 16'hffff;
      int cnt = 0;
      bit done = 0;
      speed_req = 2'd3;
      for (int i = 0; i < 60 && !done; i++) begin
         cyc();
         n_vec++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL turbo_vec: got %h expected %h", dut_vec(), exp_vec());
         end
         if (disp_is_countdown && disp_bcd !== last) begin
            obs = {obs[47:0], disp_bcd}; last = disp_bcd; cnt++;
         end
         if (fan_speed == 2'd2 && !disp_is_countdown) done = 1;
      end
      n_vec++;
      if (!done) begin n_err++; $display("FAIL turbo_timeout: got 0 expected 1"); end
      n_vec++;
      if (obs !== 64'h0003_0002_0001_0000 || cnt != 4) begin
         n_err++; $display("FAIL turbo_seq: got %h expected %h", obs, 64'h0003_0002_0001_0000);
      end
      n_vec++;
      if ({fan_speed, turbo_avail, disp_is_countdown} !== {2'd2, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL turbo_after: got %h expected %h", {fan_speed, turbo_avail, disp_is_countdown}, 4'b1000);
      end
   endtask

   task automatic test_held_turbo();
      for (int k = 0; k < 3; k++) begin
         speed_req = (k == 1) ? 2'd2 : 2'd3;
         repeat (10) begin
            cyc();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
               n_err++; $display("FAIL held_vec: got %h expected %h", dut_vec(), exp_vec());
            end
         end
      end
      n_vec++;
      if (fan_speed !== 2'd2) begin
         n_err++; $display("FAIL held_speed: got %0d expected 2", fan_speed);
      end
   endtask

   task automatic test_purge();
      logic [63:0] obs = '0;
      logic [15:0] last = 16'hffff;
      int cnt = 0;
      bit done = 0;
      speed_req = 2'd0;
      for (int i = 0; i < 40 && !done; i++) begin
         cyc();
         n_vec++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL purge_vec: got %h expected %h", dut_vec(), exp_vec());
         end
         if (disp_is_countdown && disp_bcd !== last) begin
            obs = {obs[47:0], disp_bcd}; last = disp_bcd; cnt++;
            if (fan_speed !== 2'd1) begin
               n_err++; $display("FAIL purge_speed: got %0d expected 1", fan_speed);
            end
         end
         if (fan_speed == 2'd0 && !disp_is_countdown) done = 1;
      end
      n_vec++;
      if (!done) begin n_err++; $display("FAIL purge_timeout: got 0 expected 1"); end
      n_vec++;
      if (obs !== 64'h0000_0002_0001_0000 || cnt != 3) begin
         n_err++; $display("FAIL purge_seq: got %h expected %h", obs, 64'h0000_0002_0001_0000);
      end
   endtask

   task automatic test_purge_interrupt();
      speed_req = 2'd1;
      repeat (3) cyc();
      speed_req = 2'd0;
      repeat (3) cyc();
      n_vec++;
      if (disp_is_countdown !== 1'b1) begin
         n_err++; $display("FAIL pint_purge: got %b expected 1", disp_is_countdown);
      end
      speed_req = 2'd2;
      cyc();
      n_vec++;
      if ({fan_speed, disp_is_countdown} !== {2'd2, 1'b0}) begin
         n_err++; $display("FAIL pint_run2: got %h expected %h", {fan_speed, disp_is_countdown}, 3'b100);
      end
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL pint_vec: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_tick_collision();
      bit found = 0;
      speed_req = 2'd1;
      repeat (2) cyc();
      for (int i = 0; i < 8 && !found; i++) begin
         if (m_phase == TICK_DIV - 1) found = 1; else cyc();
      end
      speed_req = 2'd0;
      cyc();
      n_vec++;
      if ({disp_is_countdown, disp_bcd} !== {1'b1, 16'h0002}) begin
         n_err++; $display("FAIL coll_load: got %h expected %h", {disp_is_countdown, disp_bcd}, {1'b1, 16'h0002});
      end
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_mode == M_PURGE && m_cd == 0 && m_phase == TICK_DIV - 1) found = 1;
         else cyc();
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL coll_timeout: got 0 expected 1"); end
      speed_req = 2'd1;
      cyc();
      n_vec++;
      if ({fan_speed, disp_is_countdown} !== {2'd1, 1'b0}) begin
         n_err++; $display("FAIL coll_expire: got %h expected %h", {fan_speed, disp_is_countdown}, 3'b010);
      end
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL coll_vec: got %h expected %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid_turbo();
      rst = 1'b1; cyc(); rst = 1'b0;
      speed_req = 2'd1; repeat (2) cyc();
      speed_req = 2'd3; repeat (3) cyc();
      n_vec++;
      if ({fan_speed, disp_is_countdown, turbo_avail} !== {2'd3, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL rmt_turbo: got %h expected %h", {fan_speed, disp_is_countdown, turbo_avail}, 4'b1110);
      end
      rst = 1'b1; cyc();
      n_vec++;
      if ({fan_speed, speed_led, disp_bcd, disp_is_countdown, turbo_avail, clean_remind} !== {2'd0, 3'd0, 16'h0, 3'b010}) begin
         n_err++; $display("FAIL rmt_reset: got %h expected %h", dut_vec(), {2'd0, 3'd0, 16'h0, 3'b010});
      end
      rst = 1'b0; speed_req = 2'd0;
   endtask

`ifdef HOOD_CLEAN_REMIND_EN
   task automatic test_clean();
      rst = 1'b1; cyc(); rst = 1'b0;
      speed_req = 2'd1;
      for (int i = 0; i < 400 && !m_remind; i++) begin
         cyc();
         n_vec++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL clean_vec: got %h expected %h", dut_vec(), exp_vec());
         end
      end
      n_vec++;
      if (clean_remind !== 1'b1) begin
         n_err++; $display("FAIL clean_set: got %b expected 1", clean_remind);
      end
      clean_ack = 1'b1; cyc(); clean_ack = 1'b0;
      n_vec++;
      if (clean_remind !== 1'b0) begin
         n_err++; $display("FAIL clean_ack: got %b expected 0", clean_remind);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) speed_req = 2'($urandom_range(0, 3));
         rst       = ($urandom_range(0, 399) == 0);
         clean_ack = ($urandom_range(0, 49) == 0);
         cyc();
         n_vec++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL random_vec: cycle %0d got %h expected %h", i, dut_vec(), exp_vec());
         end
      end
      rst = 1'b0; clean_ack = 1'b0;
   endtask

   task automatic test_wrap();
      bit found = 0;
      rst = 1'b1; cyc(); rst = 1'b0;
      speed_req = 2'd1;
      for (int i = 0; i < 25000 && !found; i++) begin
         cyc();
         n_vec++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL wrap_vec: got %h expected %h", dut_vec(), exp_vec());
         end
         if (m_cum == 5999) found = 1;
      end
      n_vec++;
      if (disp_bcd !== 16'h9959) begin
         n_err++; $display("FAIL wrap_max: got %h expected 9959", disp_bcd);
      end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         cyc();
         if (m_cum == 0) found = 1;
      end
      n_vec++;
      if ({fan_speed, disp_bcd} !== {2'd1, 16'h0000} || !found) begin
         n_err++; $display("FAIL wrap_zero: got %h expected %h", {fan_speed, disp_bcd}, {2'd1, 16'h0000});
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_level();
      test_turbo();
      test_held_turbo();
      test_purge();
      test_purge_interrupt();
      test_tick_collision();
      test_reset_mid_turbo();
`ifdef HOOD_CLEAN_REMIND_EN
      test_clean();
`endif
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
